// File: rtl/md_pkg.sv
// Shared encodings and defaults for the mult/div issue block and the mult/div unit.
package md_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic op_is_valid(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic op_is_mult(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Bits needed to hold the larger of the two busy counts (at least one bit).
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// Loadable saturating down-counter; zero_next flags that the next value is zero.
module md_busy_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero_next
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_r;

    // Load on request, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != '0) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero_next = (count_r <= ONE);

endmodule

// File: rtl/md_issue.sv
// Issue/interlock stage between the E-stage and the multi-cycle mult/div unit.
// Optional macro MD_DIVZERO_GUARD_EN suppresses divides by zero and pulses div_zero.
module md_issue
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        in_ready,
    input  logic        flush,
    output logic [3:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_busy,
    output logic        stall,
    output logic        div_zero
);

    localparam int               CNT_W     = cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    md_state_e   state_r;
    logic [3:0]  op_r;
    logic [3:0]  md_op_r;
    logic [31:0] md_a_r;
    logic [31:0] md_b_r;
    logic        div_zero_r;

    logic accept_s;
    logic div_guard_s;
    logic issue_short_s;
    logic cnt_load_s;
    logic cnt_done_s;

    assign accept_s = in_valid & op_is_valid(in_op) & ~flush;

`ifdef MD_DIVZERO_GUARD_EN
    assign div_guard_s = op_is_div(in_op) & (in_b == 32'd0);
`else
    assign div_guard_s = 1'b0;
`endif

    // A guarded divide (div_zero_r set during ISSUE) never occupies the unit.
    assign issue_short_s = ~(op_is_mult(op_r) | op_is_div(op_r)) | div_zero_r;
    assign cnt_load_s    = (state_r == ST_ISSUE) & ~flush & ~issue_short_s;

    md_busy_cnt #(
        .WIDTH (CNT_W)
    ) u_busy_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load_s),
        .load_val  (op_is_mult(op_r) ? MULT_LOAD : DIV_LOAD),
        .zero_next (cnt_done_s)
    );

    // Issue FSM; unit-facing outputs are registered and live only for the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            op_r       <= OP_NONE;
            md_op_r    <= OP_NONE;
            md_a_r     <= 32'd0;
            md_b_r     <= 32'd0;
            div_zero_r <= 1'b0;
        end else begin
            md_op_r    <= OP_NONE;
            md_a_r     <= 32'd0;
            md_b_r     <= 32'd0;
            div_zero_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_ISSUE;
                        op_r    <= in_op;
                        if (div_guard_s) begin
                            div_zero_r <= 1'b1;
                        end else begin
                            md_op_r <= in_op;
                            md_a_r  <= in_a;
                            md_b_r  <= in_b;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (flush || issue_short_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // The unit cannot be cancelled, so flush is not looked at here.
                    if (cnt_done_s && !md_busy) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Flush in the ISSUE cycle must cancel the op before the unit sees it.
    assign md_op    = flush ? 4'd0  : md_op_r;
    assign md_a     = flush ? 32'd0 : md_a_r;
    assign md_b     = flush ? 32'd0 : md_b_r;
    assign div_zero = div_zero_r & ~flush;

    assign in_ready = (state_r == ST_IDLE);
    assign stall    = in_valid & ~in_ready;

endmodule

// File: tb/tb_md_issue.sv
// Scoreboard bench for md_issue: driver predicts issues and ready timing, monitor checks the unit port.
module tb_md_issue;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_ready;
    logic        flush;
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_busy;
    logic        stall;
    logic        div_zero;

    md_issue dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_ready (in_ready),
        .flush    (flush),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
        .md_busy  (md_busy),
        .stall    (stall),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        dz;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int n = 0;
    int ready_from = 0;
    int busy_lo = 0;
    int busy_hi = -1;
    int issue_at = -1;
    logic [3:0]  pend_op;
    logic [31:0] pend_a;
    logic [31:0] pend_b;
    bit extra_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, n, act, req);
        end
    endtask

    // Model of one issue: what the unit sees and when the block is ready again.
    task automatic resolve(input logic fl);
        exp_t e;
        int   k;
        int   len;
        int   leave;
        issue_at = -1;
        if (fl) begin
            ready_from = n + 1;
            return;
        end
        e.cyc = n; e.op = pend_op; e.a = pend_a; e.b = pend_b; e.dz = 1'b0;
        ready_from = n + 1;
`ifdef MD_DIVZERO_GUARD_EN
        if ((pend_op == 4'd3 || pend_op == 4'd4) && pend_b == 32'd0) begin
            e.op = 4'd0; e.a = 32'd0; e.b = 32'd0; e.dz = 1'b1;
            q.push_back(e);
            return;
        end
`endif
        if (pend_op >= 4'd1 && pend_op <= 4'd4) begin
            len = (pend_op <= 4'd2) ? 5 : 10;
            k = extra_busy ? $urandom_range(len + 3, 0) : 0;
            busy_lo = n + 1;
            busy_hi = n + k;
            leave = (n + len > n + 1 + k) ? n + len : n + 1 + k;
            ready_from = leave + 1;
        end
        q.push_back(e);
    endtask

    // One clock of stimulus, entered and left at a falling edge.
    task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic fl, output bit acc);
        logic exp_ready;
        in_valid = v; in_op = op; in_a = a; in_b = b; flush = fl;
        md_busy = (n >= busy_lo) && (n <= busy_hi);
        if (n == issue_at) resolve(fl);
        exp_ready = (n >= ready_from);
        acc = exp_ready && v && op >= 4'd1 && op <= 4'd8 && !fl;
        if (acc) begin
            pend_op = op; pend_a = a; pend_b = b;
            issue_at = n + 1;
            ready_from = n + 1000;
        end
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        chk("stall", {31'd0, stall}, {31'd0, v & ~exp_ready});
        @(negedge clk);
        n++;
    endtask

    task automatic hold(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit acc;
        int t;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 40) begin
            cyc(1'b1, op, a, b, 1'b0, acc);
            t++;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL hold_timeout cycle=%0d actual=not_accepted required=accepted", n);
        end
    endtask

    task automatic idle(input int m);
        bit acc;
        for (int i = 0; i < m; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, acc);
    endtask

    // Monitor: every non-NONE issue (or div_zero pulse) must match the next expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                if (md_op !== 4'd0 || div_zero !== 1'b0) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_issue cycle=%0d actual=%0h required=none", n, md_op);
                    end else begin
                        e = q.pop_front();
                        chk("issue_cycle", n, e.cyc);
                        chk("md_op", {28'd0, md_op}, {28'd0, e.op});
                        chk("md_a", md_a, e.a);
                        chk("md_b", md_b, e.b);
                        chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                    end
                end else begin
                    chk("idle_md_a", md_a, 32'd0);
                    chk("idle_md_b", md_b, 32'd0);
                end
            end
        end
    end

    initial begin
        bit acc;
        reset = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_a = 32'd0; in_b = 32'd0;
        flush = 1'b0; md_busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_md_op", {28'd0, md_op}, 32'd0);
        chk("rst_md_a", md_a, 32'd0);
        chk("rst_md_b", md_b, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        reset = 1'b0;
        n = 0;
        ready_from = 0;

        // Mult, then reads.
        hold(4'd1, 32'd3, 32'hFFFF_FFFE);
        hold(4'd6, 32'd0, 32'd0);
        hold(4'd5, 32'd0, 32'd0);
        // Divide with a dependent read held valid throughout.
        hold(4'd4, 32'd100, 32'd7);
        hold(4'd5, 32'd0, 32'd0);
        // Move-to then move-from back to back.
        hold(4'd7, 32'h0000_1234, 32'd0);
        hold(4'd5, 32'd0, 32'd0);
        // Flush coincident with the ISSUE cycle of a mult.
        hold(4'd1, 32'd5, 32'd6);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, acc);
        idle(2);
        // Divide by zero.
        hold(4'd3, 32'd9, 32'd0);
        idle(14);
        // Reset in the 4th BUSY cycle of a divide.
        hold(4'd3, 32'd50, 32'd3);
        idle(4);
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; md_busy = 1'b0;
        @(negedge clk);
        n++;
        reset = 1'b0;
        ready_from = n;
        busy_hi = -1;
        issue_at = -1;
        chk("rst_busy_md_op", {28'd0, md_op}, 32'd0);
        chk("rst_busy_in_ready", {31'd0, in_ready}, 32'd1);
        idle(2);

        // Randomized traffic with a unit that may hold busy past the countdown.
        extra_busy = 1'b1;
        for (int i = 0; i < 700; i++) begin
            logic [3:0]  op;
            logic [31:0] b;
            op = ($urandom_range(15, 0) == 0) ? 4'd15 : 4'($urandom_range(9, 0));
            b = ($urandom_range(3, 0) == 0) ? 32'd0 : $urandom;
            cyc($urandom_range(3, 0) != 0, op, $urandom, b, $urandom_range(7, 0) == 0, acc);
        end
        idle(30);
        chk("queue_empty", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
